lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store unit that consumes the memory-access control bundle (MemWrite, MemType, MemSign) produced by instruction decode, together with the ALU-computed address and rs2 data. It drives a word-addressed data-memory port that has a request/grant handshake and a separate read-valid return. It performs byte-lane steering, byte enables and load extension, and splits misaligned accesses into two word transactions. It stalls the core via Busy_o until the access completes.

## Interface
- DATA_WIDTH, 32, width of address, data and memory words (the block is defined for 32 only)
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous, active-high reset
- Req_i  input  1  access request from the datapath, sampled only in IDLE
- MemWrite_i  input  1  1 = store, 0 = load
- MemType_i  input  2  00 word, 01 byte, 10 half, 11 treated as word
- MemSign_i  input  1  load extension: 0 = sign-extend, 1 = zero-extend; ignored for stores and for word loads
- Addr_i  input  32  byte address
- WriteData_i  input  32  store data, right-aligned
- Busy_o  output  1  high whenever state != IDLE
- Done_o  output  1  one-cycle completion pulse
- ReadData_o  output  32  extended load result; holds its value until the next load's Done_o
- MemReq_o  output  1  memory request, held until granted
- MemWe_o  output  1  write strobe qualifying MemReq_o
- MemAddr_o  output  32  word-aligned address, bits [1:0] = 00
- MemBe_o  output  4  byte enables
- MemWData_o  output  32  lane-steered store data
- MemGnt_i  input  1  grant; a transfer occurs in a cycle with MemReq_o && MemGnt_i
- MemRValid_i  input  1  read data valid, arrives 1 or more cycles after the read grant
- MemRData_i  input  32  read data

## Operation
- Offset o = Addr_i[1:0]. The access is misaligned when it is a half with o = 3, or a word with o != 0.
- Aligned access:
  - Byte: BE = 0001 << o.
  - Half: BE = 0011 << o.
  - Word: BE = 1111.
  - Store data: WriteData_i << 8*o.
- Misaligned access: two transactions.
  - First transaction: word A = Addr_i & ~3, BE = (full mask << o)[3:0], data = WriteData_i << 8*o.
  - Second transaction: A + 4 (wraps mod 2^32), BE = full mask >> (4 - o), data = WriteData_i >> 8*(4 - o).
- Loads:
  - Capture each beat on MemRValid_i.
  - Merge as {beat1, beat0} >> 8*o, using beat1 = 0 when aligned.
  - Take the low 8/16/32 bits and extend according to MemSign_i.
- All request fields (type, sign, offset, data, address) are latched at acceptance. Inputs may change while Busy_o is high.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
  - IDLE -> REQ0 on Req_i.
  - REQ0: on grant, go to WAIT0 for a load; for a store go to REQ1 if split, else DONE.
  - WAIT0: on MemRValid_i, go to REQ1 if split, else DONE.
  - REQ1: on grant, go to WAIT1 for a load, else DONE.
  - WAIT1 -> DONE on MemRValid_i.
  - DONE -> IDLE unconditionally.
- MemRValid_i outside WAIT0/WAIT1 is ignored.
- Req_i while not in IDLE is ignored.

## Timing
- Reset values: state IDLE; Busy_o, Done_o, MemReq_o and MemWe_o = 0; MemAddr_o, MemBe_o, MemWData_o and ReadData_o = 0.
- All memory-side outputs are registered. MemReq_o rises the cycle after Req_i is accepted.
- MemReq_o, MemWe_o, MemAddr_o, MemBe_o and MemWData_o stay stable until the grant cycle. MemReq_o drops the cycle after the grant.
- Done_o is asserted the cycle after the final grant (store) or final MemRValid_i (load). ReadData_o is valid in that same cycle.
- Minimum latency from Req_i to Done_o, with zero-wait grant and MemRValid_i one cycle after grant:
  - Aligned store: 2 cycles.
  - Aligned load: 3 cycles.
  - Split store: 3 cycles.
  - Split load: 5 cycles.
- Busy_o is combinational from state, so it is high in the DONE cycle. Back-to-back requests are possible from the following cycle.
- Asynchronous reset mid-transaction:
  - Immediately returns to IDLE with MemReq_o = 0.
  - Leaves ReadData_o = 0.
  - A late MemRValid_i after reset is ignored.
- A grant in the same cycle as a reset deassertion edge is not a transfer, because MemReq_o is 0 then.

## Structure
- Shared package (riscv_pkg):
  - mem_type_t enum: MT_WORD = 2'b00, MT_BYTE = 2'b01, MT_HALF = 2'b10.
  - lsu_state_t enum.
  - Constants for the 32-bit data width.
- Decode uses the same mem_type_t encoding.
- One combinational sub-module, lsu_align, holds all lane logic: BE generation, store shifting, the split flag, beat merge and extension.
- lsu_ctrl holds the FSM and registers only.

## Test plan
- Aligned LW, Addr 0x100, memory word 0xDEADBEEF, zero-wait -> MemAddr_o 0x100, BE 1111, Done_o at cycle 3, ReadData_o 0xDEADBEEF.
- LB at 0x103, MemSign 0, byte 0x80 -> BE 1000, ReadData_o 0xFFFFFF80; the same access with MemSign 1 -> 0x00000080.
- SH, Addr 0x203, data 0x0000ABCD -> first transfer 0x200, BE 1000, data 0xCD000000; second transfer 0x204, BE 0001, data 0x000000AB; Done_o 3 cycles after Req_i.
- LW, Addr 0xFFFFFFFE, words 0x11223344 at 0xFFFFFFFC and 0x55667788 at 0x0 -> second MemAddr_o 0x00000000, ReadData_o 0x77881122.
- Grant withheld 4 cycles, then MemRValid_i delayed 3 cycles -> MemReq_o and the request fields stay stable; Busy_o stays high; Req_i pulses during Busy_o are ignored.
- rst_i asserted in WAIT0, then MemRValid_i pulsed 2 cycles later -> immediately IDLE, MemReq_o 0, no Done_o, ReadData_o 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared memory-access types, LSU state encoding and lane helpers
package riscv_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    MT_WORD = 2'b00,
    MT_BYTE = 2'b01,
    MT_HALF = 2'b10
  } mem_type_t;

  typedef enum logic [2:0] {
    LS_IDLE  = 3'd0,
    LS_REQ0  = 3'd1,
    LS_WAIT0 = 3'd2,
    LS_REQ1  = 3'd3,
    LS_WAIT1 = 3'd4,
    LS_DONE  = 3'd5
  } lsu_state_t;

  // Right-aligned byte mask of the access size; encoding 11 behaves as a word.
  function automatic logic [BE_W-1:0] type_mask(input logic [1:0] mem_type);
    case (mem_type)
      MT_BYTE: type_mask = 4'b0001;
      MT_HALF: type_mask = 4'b0011;
      default: type_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, byte enables, split detection and load extension
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]        mem_type_i,
  input  logic              mem_sign_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] beat0_i,
  input  logic [DATA_W-1:0] beat1_i,
  output logic              split_o,
  output logic [BE_W-1:0]   be0_o,
  output logic [BE_W-1:0]   be1_o,
  output logic [DATA_W-1:0] wdata0_o,
  output logic [DATA_W-1:0] wdata1_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [2*BE_W-1:0]   be_wide;
  logic [2*DATA_W-1:0] wdata_wide;
  logic [2*DATA_W-1:0] merged;
  logic                unused_merged_hi;

  always_comb begin
    split_o = 1'b0;
    if (mem_type_i == MT_HALF) begin
      split_o = (offset_i == 2'd3);
    end else if (mem_type_i != MT_BYTE) begin
      split_o = (offset_i != 2'd0);
    end
  end

  // Shifting into a double-width word yields both beats at once: the low
  // half is the first transaction, the spill-over is the second.
  always_comb begin
    be_wide    = {4'b0000, type_mask(mem_type_i)} << offset_i;
    wdata_wide = {{DATA_W{1'b0}}, wdata_i} << {offset_i, 3'b000};
  end

  assign be0_o    = be_wide[BE_W-1:0];
  assign be1_o    = be_wide[2*BE_W-1:BE_W];
  assign wdata0_o = wdata_wide[DATA_W-1:0];
  assign wdata1_o = wdata_wide[2*DATA_W-1:DATA_W];

  always_comb begin
    merged = {(split_o ? beat1_i : {DATA_W{1'b0}}), beat0_i} >> {offset_i, 3'b000};
    case (mem_type_i)
      MT_BYTE: rdata_o = {{24{~mem_sign_i & merged[7]}}, merged[7:0]};
      MT_HALF: rdata_o = {{16{~mem_sign_i & merged[15]}}, merged[15:0]};
      default: rdata_o = merged[DATA_W-1:0];
    endcase
  end

  assign unused_merged_hi = ^merged[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit FSM driving a request/grant data-memory port
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    Req_i,
  input  logic                    MemWrite_i,
  input  logic [1:0]              MemType_i,
  input  logic                    MemSign_i,
  input  logic [DATA_WIDTH-1:0]   Addr_i,
  input  logic [DATA_WIDTH-1:0]   WriteData_i,
  output logic                    Busy_o,
  output logic                    Done_o,
  output logic [DATA_WIDTH-1:0]   ReadData_o,
  output logic                    MemReq_o,
  output logic                    MemWe_o,
  output logic [DATA_WIDTH-1:0]   MemAddr_o,
  output logic [DATA_WIDTH/8-1:0] MemBe_o,
  output logic [DATA_WIDTH-1:0]   MemWData_o,
  input  logic                    MemGnt_i,
  input  logic                    MemRValid_i,
  input  logic [DATA_WIDTH-1:0]   MemRData_i
);

  localparam logic [2:0] ST_IDLE  = LS_IDLE;
  localparam logic [2:0] ST_REQ0  = LS_REQ0;
  localparam logic [2:0] ST_WAIT0 = LS_WAIT0;
  localparam logic [2:0] ST_REQ1  = LS_REQ1;
  localparam logic [2:0] ST_WAIT1 = LS_WAIT1;
  localparam logic [2:0] ST_DONE  = LS_DONE;

  logic [2:0]              state_q, state_d;
  logic                    write_q, write_d;
  logic [1:0]              type_q, type_d;
  logic                    sign_q, sign_d;
  logic [1:0]              off_q, off_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-3:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   beat0_q, beat0_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH/8-1:0] mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic                    idle;
  logic [1:0]              al_type;
  logic                    al_sign;
  logic [1:0]              al_off;
  logic [DATA_WIDTH-1:0]   al_wdata;
  logic [DATA_WIDTH-1:0]   al_beat0;
  logic                    al_split;
  logic [DATA_WIDTH/8-1:0] al_be0, al_be1;
  logic [DATA_WIDTH-1:0]   al_wdata0, al_wdata1, al_rdata;
  logic [DATA_WIDTH-1:0]   next_addr;

  // In IDLE the lane logic sees the live request so the first beat can be
  // registered at acceptance; afterwards it works from the latched copy.
  assign idle      = (state_q == ST_IDLE);
  assign al_type   = idle ? MemType_i   : type_q;
  assign al_sign   = idle ? MemSign_i   : sign_q;
  assign al_off    = idle ? Addr_i[1:0] : off_q;
  assign al_wdata  = idle ? WriteData_i : wdata_q;
  assign al_beat0  = (state_q == ST_WAIT0) ? MemRData_i : beat0_q;
  assign next_addr = {waddr_q + 1'b1, 2'b00};

  lsu_align u_align (
    .mem_type_i (al_type),
    .mem_sign_i (al_sign),
    .offset_i   (al_off),
    .wdata_i    (al_wdata),
    .beat0_i    (al_beat0),
    .beat1_i    (MemRData_i),
    .split_o    (al_split),
    .be0_o      (al_be0),
    .be1_o      (al_be1),
    .wdata0_o   (al_wdata0),
    .wdata1_o   (al_wdata1),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    type_d      = type_q;
    sign_d      = sign_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    beat0_d     = beat0_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (Req_i) begin
          write_d     = MemWrite_i;
          type_d      = MemType_i;
          sign_d      = MemSign_i;
          off_d       = Addr_i[1:0];
          wdata_d     = WriteData_i;
          waddr_d     = Addr_i[DATA_WIDTH-1:2];
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite_i;
          mem_addr_d  = {Addr_i[DATA_WIDTH-1:2], 2'b00};
          mem_be_d    = al_be0;
          mem_wdata_d = al_wdata0;
          state_d     = ST_REQ0;
        end
      end
      ST_REQ0: begin
        if (MemGnt_i) begin
          if (!write_q) begin
            mem_req_d = 1'b0;
            state_d   = ST_WAIT0;
          end else if (al_split) begin
            // Second store beat issues straight after the first grant.
            mem_addr_d  = next_addr;
            mem_be_d    = al_be1;
            mem_wdata_d = al_wdata1;
            state_d     = ST_REQ1;
          end else begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_WAIT0: begin
        if (MemRValid_i) begin
          beat0_d = MemRData_i;
          if (al_split) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = next_addr;
            mem_be_d    = al_be1;
            mem_wdata_d = al_wdata1;
            state_d     = ST_REQ1;
          end else begin
            rdata_d = al_rdata;
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ1: begin
        if (MemGnt_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = write_q ? ST_DONE : ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (MemRValid_i) begin
          rdata_d = al_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      type_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      waddr_q     <= '0;
      beat0_q     <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      type_q      <= type_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      beat0_q     <= beat0_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign Busy_o     = (state_q != ST_IDLE);
  assign Done_o     = (state_q == ST_DONE);
  assign ReadData_o = rdata_q;
  assign MemReq_o   = mem_req_q;
  assign MemWe_o    = mem_we_q;
  assign MemAddr_o  = mem_addr_q;
  assign MemBe_o    = mem_be_q;
  assign MemWData_o = mem_wdata_q;

endmodule
